// File: rtl/pp_loop_status_tracker.sv
// ============================================================================
// Module  : pp_loop_status_tracker
// Brief   : Observes a block handshake and a pipelined loop, keeps saturating
//           run/iteration statistics; optional stall counter under the macro
//           PP_LOOP_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_loop_status_tracker #(
    parameter int STATE_W = 9,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic               finish,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] post_loop_state0,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic [STATE_W-1:0] loop_quit_state,
    input  logic               iter_start_enable,
    input  logic               iter_start_block,
    input  logic               iter_end_enable,
    input  logic               iter_end_block,
    input  logic               quit_at_end,
    output logic               mod_busy,
    output logic [CNT_W-1:0]   mod_start_cnt,
    output logic [CNT_W-1:0]   mod_done_cnt,
    output logic [CNT_W-1:0]   mod_last_lat,
    output logic               loop_active,
    output logic [CNT_W-1:0]   loop_cnt,
    output logic [CNT_W-1:0]   iter_start_cnt,
    output logic [CNT_W-1:0]   iter_end_cnt,
    output logic               frozen
`ifdef PP_LOOP_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]   stall_cnt
`endif
);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_BUSY      = 2'd1;
    localparam logic [1:0] S_WAIT_CONT = 2'd2;

    localparam logic [CNT_W-1:0] c_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + c_ONE;
    endfunction

    logic [1:0]       mod_state_q, mod_state_d;
    logic [CNT_W-1:0] mod_start_q, mod_start_d;
    logic [CNT_W-1:0] mod_done_q,  mod_done_d;
    logic [CNT_W-1:0] lat_q,       lat_d;
    logic [CNT_W-1:0] last_lat_q,  last_lat_d;
    logic             loop_active_q, loop_active_d;
    logic [CNT_W-1:0] loop_cnt_q,  loop_cnt_d;
    logic [CNT_W-1:0] it_start_q,  it_start_d;
    logic [CNT_W-1:0] it_end_q,    it_end_d;
    logic             frozen_q,    frozen_d;

    logic hold;
    logic start_ev;
    logic end_ev;
    logic loop_exit;

    // finish suppresses events in its own cycle, not only after frozen sets
    assign hold     = frozen_q | finish;
    assign start_ev = (|(cur_state & iter_start_state)) & iter_start_enable & ~iter_start_block;
    assign end_ev   = (|(cur_state & iter_end_state)) & iter_end_enable & ~iter_end_block;

    always_comb begin
        mod_state_d = mod_state_q;
        mod_start_d = mod_start_q;
        mod_done_d  = mod_done_q;
        lat_d       = lat_q;
        last_lat_d  = last_lat_q;
        if (!hold) begin
            case (mod_state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        mod_state_d = S_BUSY;
                        mod_start_d = sat_inc(mod_start_q);
                        lat_d       = c_ONE;
                    end
                end
                S_BUSY: begin
                    if (ap_done) begin
                        mod_done_d  = sat_inc(mod_done_q);
                        last_lat_d  = lat_q;
                        mod_state_d = ap_continue ? S_IDLE : S_WAIT_CONT;
                    end else begin
                        lat_d = sat_inc(lat_q);
                    end
                end
                S_WAIT_CONT: begin
                    if (ap_continue) begin
                        mod_state_d = S_IDLE;
                    end
                end
                default: mod_state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        it_start_d    = it_start_q;
        it_end_d      = it_end_q;
        loop_active_d = loop_active_q;
        loop_cnt_d    = loop_cnt_q;
        loop_exit     = 1'b0;
        if (!hold) begin
            if (start_ev) it_start_d = sat_inc(it_start_q);
            if (end_ev)   it_end_d   = sat_inc(it_end_q);
            // drain check uses this cycle's updated counts
            loop_exit = loop_active_q &
                        (((~|(cur_state & loop_quit_state)) &
                          (~quit_at_end | (it_end_d == it_start_d))) |
                         (cur_state == post_loop_state0));
            if (loop_exit) begin
                loop_active_d = 1'b0;
                loop_cnt_d    = sat_inc(loop_cnt_q);
            end else if (start_ev && !loop_active_q) begin
                loop_active_d = 1'b1;
            end
        end
    end

    assign frozen_d = frozen_q | finish;

    always_ff @(posedge clock) begin
        if (!reset) begin
            mod_state_q   <= S_IDLE;
            mod_start_q   <= '0;
            mod_done_q    <= '0;
            lat_q         <= '0;
            last_lat_q    <= '0;
            loop_active_q <= 1'b0;
            loop_cnt_q    <= '0;
            it_start_q    <= '0;
            it_end_q      <= '0;
            frozen_q      <= 1'b0;
        end else begin
            mod_state_q   <= mod_state_d;
            mod_start_q   <= mod_start_d;
            mod_done_q    <= mod_done_d;
            lat_q         <= lat_d;
            last_lat_q    <= last_lat_d;
            loop_active_q <= loop_active_d;
            loop_cnt_q    <= loop_cnt_d;
            it_start_q    <= it_start_d;
            it_end_q      <= it_end_d;
            frozen_q      <= frozen_d;
        end
    end

`ifdef PP_LOOP_STALL_CNT_EN
    logic [CNT_W-1:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!hold && loop_active_q && iter_start_block) begin
            stall_d = sat_inc(stall_q);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`endif

    assign mod_busy       = (mod_state_q != S_IDLE);
    assign mod_start_cnt  = mod_start_q;
    assign mod_done_cnt   = mod_done_q;
    assign mod_last_lat   = last_lat_q;
    assign loop_active    = loop_active_q;
    assign loop_cnt       = loop_cnt_q;
    assign iter_start_cnt = it_start_q;
    assign iter_end_cnt   = it_end_q;
    assign frozen         = frozen_q;

endmodule

`default_nettype wire

// File: tb/tb_pp_loop_status_tracker.sv
// ============================================================================
// Module  : tb_pp_loop_status_tracker
// Brief   : Directed self-checking bench for pp_loop_status_tracker; narrow
//           counters (CNT_W=4) so saturation is reachable. Honours the macro
//           PP_LOOP_STALL_CNT_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_loop_status_tracker;

    localparam int STATE_W = 9;
    localparam int CNT_W   = 4;

    localparam logic [STATE_W-1:0] c_B0 = 9'b000000001;
    localparam logic [STATE_W-1:0] c_B1 = 9'b000000010;
    localparam logic [STATE_W-1:0] c_B2 = 9'b000000100;
    localparam logic [STATE_W-1:0] c_B3 = 9'b000001000;

    logic               clock = 1'b0;
    logic               reset;
    logic               ap_start, ap_done, ap_continue, finish;
    logic [STATE_W-1:0] cur_state;
    logic [STATE_W-1:0] post_loop_state0, iter_start_state, iter_end_state, loop_quit_state;
    logic               iter_start_enable, iter_start_block, iter_end_enable, iter_end_block;
    logic               quit_at_end;
    logic               mod_busy, loop_active, frozen;
    logic [CNT_W-1:0]   mod_start_cnt, mod_done_cnt, mod_last_lat;
    logic [CNT_W-1:0]   loop_cnt, iter_start_cnt, iter_end_cnt;
`ifdef PP_LOOP_STALL_CNT_EN
    logic [CNT_W-1:0]   stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pp_loop_status_tracker #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
        .clock             (clock),
        .reset             (reset),
        .ap_start          (ap_start),
        .ap_done           (ap_done),
        .ap_continue       (ap_continue),
        .finish            (finish),
        .cur_state         (cur_state),
        .post_loop_state0  (post_loop_state0),
        .iter_start_state  (iter_start_state),
        .iter_end_state    (iter_end_state),
        .loop_quit_state   (loop_quit_state),
        .iter_start_enable (iter_start_enable),
        .iter_start_block  (iter_start_block),
        .iter_end_enable   (iter_end_enable),
        .iter_end_block    (iter_end_block),
        .quit_at_end       (quit_at_end),
        .mod_busy          (mod_busy),
        .mod_start_cnt     (mod_start_cnt),
        .mod_done_cnt      (mod_done_cnt),
        .mod_last_lat      (mod_last_lat),
        .loop_active       (loop_active),
        .loop_cnt          (loop_cnt),
        .iter_start_cnt    (iter_start_cnt),
        .iter_end_cnt      (iter_end_cnt),
        .frozen            (frozen)
`ifdef PP_LOOP_STALL_CNT_EN
        ,
        .stall_cnt         (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // one rising edge, then settle so outputs are sampled away from the edge
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_loop(input logic [STATE_W-1:0] st, input logic se, input logic sb,
                            input logic ee, input logic eb);
        cur_state         = st;
        iter_start_enable = se;
        iter_start_block  = sb;
        iter_end_enable   = ee;
        iter_end_block    = eb;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {31'd0, mod_busy},    32'd0);
        chk({tag, "_mstart"}, {28'd0, mod_start_cnt}, 32'd0);
        chk({tag, "_mdone"},  {28'd0, mod_done_cnt},  32'd0);
        chk({tag, "_lat"},    {28'd0, mod_last_lat},  32'd0);
        chk({tag, "_lact"},   {31'd0, loop_active}, 32'd0);
        chk({tag, "_lcnt"},   {28'd0, loop_cnt},      32'd0);
        chk({tag, "_istart"}, {28'd0, iter_start_cnt}, 32'd0);
        chk({tag, "_iend"},   {28'd0, iter_end_cnt},  32'd0);
        chk({tag, "_frozen"}, {31'd0, frozen},      32'd0);
`ifdef PP_LOOP_STALL_CNT_EN
        chk({tag, "_stall"},  {28'd0, stall_cnt},     32'd0);
`endif
    endtask

    initial begin
        reset = 1'b0; ap_start = 1'b0; ap_done = 1'b0; ap_continue = 1'b0; finish = 1'b0;
        quit_at_end      = 1'b1;
        post_loop_state0 = c_B2;
        iter_start_state = c_B1;
        iter_end_state   = c_B1 | c_B3;
        loop_quit_state  = c_B1 | c_B2;
        set_loop(c_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();
        chk_all_zero("rst");
        reset = 1'b1;

        // single run: start, done five cycles later, continue high
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        chk("run1_busy", {31'd0, mod_busy}, 32'd1);
        chk("run1_start", {28'd0, mod_start_cnt}, 32'd1);
        repeat (4) tick();
        ap_done = 1'b1; ap_continue = 1'b1; tick(); ap_done = 1'b0; ap_continue = 1'b0;
        chk("run1_done", {28'd0, mod_done_cnt}, 32'd1);
        chk("run1_lat", {28'd0, mod_last_lat}, 32'd5);
        chk("run1_idle", {31'd0, mod_busy}, 32'd0);

        // done without continue parks in WAIT_CONT and ignores a new start
        ap_start = 1'b1; tick(); ap_start = 1'b0;
        chk("run2_start", {28'd0, mod_start_cnt}, 32'd2);
        ap_done = 1'b1; tick(); ap_done = 1'b0;
        chk("run2_done", {28'd0, mod_done_cnt}, 32'd2);
        chk("run2_lat", {28'd0, mod_last_lat}, 32'd1);
        chk("run2_wait", {31'd0, mod_busy}, 32'd1);
        ap_start = 1'b1; tick(); ap_start = 1'b0; tick(); tick();
        chk("run2_nostart", {28'd0, mod_start_cnt}, 32'd2);
        chk("run2_stillbusy", {31'd0, mod_busy}, 32'd1);
        ap_continue = 1'b1; tick(); ap_continue = 1'b0;
        chk("run2_idle", {31'd0, mod_busy}, 32'd0);

        // 8 iterations, depth 3, exit only once the pipeline drains
        set_loop(c_B1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("l1_active", {31'd0, loop_active}, 32'd1);
        chk("l1_s1", {28'd0, iter_start_cnt}, 32'd1);
        tick();
        set_loop(c_B1, 1'b1, 1'b0, 1'b1, 1'b0); repeat (6) tick();
        chk("l1_s8", {28'd0, iter_start_cnt}, 32'd8);
        chk("l1_e6", {28'd0, iter_end_cnt}, 32'd6);
        set_loop(c_B3, 1'b0, 1'b0, 1'b1, 1'b0); tick();
        chk("l1_e7", {28'd0, iter_end_cnt}, 32'd7);
        chk("l1_draining", {31'd0, loop_active}, 32'd1);
        tick();
        chk("l1_e8", {28'd0, iter_end_cnt}, 32'd8);
        chk("l1_exit", {31'd0, loop_active}, 32'd0);
        chk("l1_lcnt", {28'd0, loop_cnt}, 32'd1);
        set_loop(c_B0, 1'b0, 1'b0, 1'b0, 1'b0); tick();

        // quit_at_end=0: leaving the quit state exits despite unequal counts
        quit_at_end = 1'b0;
        set_loop(c_B1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("l2_s9", {28'd0, iter_start_cnt}, 32'd9);
        set_loop(c_B3, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("l2_exit", {31'd0, loop_active}, 32'd0);
        chk("l2_lcnt", {28'd0, loop_cnt}, 32'd2);

        // post-loop state forces exit even while counts differ
        quit_at_end = 1'b1;
        set_loop(c_B1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("l3_active", {31'd0, loop_active}, 32'd1);
        set_loop(c_B2, 1'b0, 1'b0, 1'b0, 1'b0); tick();
        chk("l3_exit", {31'd0, loop_active}, 32'd0);
        chk("l3_lcnt", {28'd0, loop_cnt}, 32'd3);

        // blocked stages count nothing
        set_loop(c_B1, 1'b1, 1'b0, 1'b0, 1'b0); tick();
        chk("l4_s11", {28'd0, iter_start_cnt}, 32'd11);
        set_loop(c_B1, 1'b1, 1'b1, 1'b1, 1'b1); repeat (4) tick();
        chk("blk_start", {28'd0, iter_start_cnt}, 32'd11);
        chk("blk_end", {28'd0, iter_end_cnt}, 32'd8);
`ifdef PP_LOOP_STALL_CNT_EN
        chk("blk_stall", {28'd0, stall_cnt}, 32'd4);
`endif

        // saturation at all-ones (15 for 4-bit counters)
        set_loop(c_B1, 1'b1, 1'b0, 1'b0, 1'b0); repeat (6) tick();
        chk("sat_start", {28'd0, iter_start_cnt}, 32'd15);
        chk("sat_active", {31'd0, loop_active}, 32'd1);

        // finish suppresses the same-cycle end event and freezes everything
        finish = 1'b1; set_loop(c_B1, 1'b0, 1'b0, 1'b1, 1'b0); tick(); finish = 1'b0;
        chk("frz_flag", {31'd0, frozen}, 32'd1);
        chk("frz_end_same", {28'd0, iter_end_cnt}, 32'd8);
        set_loop(c_B2, 1'b1, 1'b1, 1'b1, 1'b0); ap_start = 1'b1; repeat (3) tick();
        ap_start = 1'b0;
        chk("frz_end", {28'd0, iter_end_cnt}, 32'd8);
        chk("frz_active", {31'd0, loop_active}, 32'd1);
        chk("frz_lcnt", {28'd0, loop_cnt}, 32'd3);
        chk("frz_mstart", {28'd0, mod_start_cnt}, 32'd2);
        chk("frz_busy", {31'd0, mod_busy}, 32'd0);
        chk("frz_sticky", {31'd0, frozen}, 32'd1);
`ifdef PP_LOOP_STALL_CNT_EN
        chk("frz_stall", {28'd0, stall_cnt}, 32'd4);
`endif

        // reset clears everything, including frozen
        set_loop(c_B0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0; tick(); reset = 1'b1;
        chk_all_zero("rst2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
